// File: rtl/prvp_pulp_clock_switch_ctrl.sv
// Glitch-free clock mux select sequencer: gate, wait for target lock, switch, ungate.
// Runs in the always-on reference clock domain with a 4-phase req/ack handshake.
module prvp_pulp_clock_switch_ctrl #(
  parameter int unsigned GATE_WAIT    = 4,
  parameter int unsigned MUX_WAIT     = 2,
  parameter int unsigned LOCK_TIMEOUT = 16,
  parameter logic        DEFAULT_SEL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic sel_i,
  input  logic lock0_i,
  input  logic lock1_i,
  output logic clk_sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic ack_o,
  output logic err_o
);

  localparam int unsigned MAX_GM  = (GATE_WAIT > MUX_WAIT) ? GATE_WAIT : MUX_WAIT;
  localparam int unsigned CNT_MAX = (MAX_GM > LOCK_TIMEOUT) ? MAX_GM : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] MUX_LAST  = CNT_W'(MUX_WAIT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GATE_OFF  = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_SWITCH    = 3'd3;
  localparam logic [2:0] S_GATE_ON   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             err_flag_q, err_flag_d;
  logic             clk_sel_q, clk_sel_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             lock_tgt_c;

  assign lock_tgt_c = target_q ? lock1_i : lock0_i;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    err_flag_d = err_flag_q;

    case (state_q)
      S_IDLE: begin
        err_flag_d = 1'b0;
        if (req_i) begin
          if (sel_i == clk_sel_q) begin
            state_d = S_DONE;
          end else begin
            target_d = sel_i;
            state_d  = S_GATE_OFF;
          end
        end
      end
      S_GATE_OFF: begin
        if (cnt_q == GATE_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock wins over a timeout landing in the same cycle
        if (lock_tgt_c) begin
          state_d = S_SWITCH;
        end else if ((LOCK_TIMEOUT != 0) && (cnt_q == LOCK_LAST)) begin
          err_flag_d = 1'b1;
          state_d    = S_GATE_ON;
        end
      end
      S_SWITCH: begin
        if (cnt_q == MUX_LAST) state_d = S_GATE_ON;
      end
      S_GATE_ON: begin
        if (cnt_q == GATE_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (!req_i) begin
          state_d    = S_IDLE;
          err_flag_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);

    clk_en_d  = !((state_d == S_GATE_OFF) || (state_d == S_WAIT_LOCK) || (state_d == S_SWITCH));
    clk_sel_d = (state_d == S_SWITCH) ? target_q : clk_sel_q;
    busy_d    = (state_d != S_IDLE);
    ack_d     = (state_d == S_DONE);
    err_d     = (state_d == S_DONE) && err_flag_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      target_q   <= DEFAULT_SEL;
      err_flag_q <= 1'b0;
      clk_sel_q  <= DEFAULT_SEL;
      clk_en_q   <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      err_flag_q <= err_flag_d;
      clk_sel_q  <= clk_sel_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign clk_sel_o = clk_sel_q;
  assign clk_en_o  = clk_en_q;
  assign busy_o    = busy_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_prvp_pulp_clock_switch_ctrl.sv
// Bench for the clock switch sequencer: directed and randomized handshakes
// checked against an event-time model of the switch sequence.
module tb_prvp_pulp_clock_switch_ctrl;

  localparam int GW = 4;
  localparam int MW = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, sel = 1'b0, lk0 = 1'b0, lk1 = 1'b0;
  logic sel_o, en_o, busy_o, ack_o, err_o;
  logic req2 = 1'b0, sel2 = 1'b0, lk0_2 = 1'b0, lk1_2 = 1'b0;
  logic sel2_o, en2_o, busy2_o, ack2_o, err2_o;

  int tests = 0;
  int fails = 0;
  logic cur_sel = 1'b0;

  always #5 clk = ~clk;

  prvp_pulp_clock_switch_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .sel_i(sel),
    .lock0_i(lk0), .lock1_i(lk1), .clk_sel_o(sel_o), .clk_en_o(en_o),
    .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o)
  );

  prvp_pulp_clock_switch_ctrl #(.LOCK_TIMEOUT(0)) dut_nt (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .sel_i(sel2),
    .lock0_i(lk0_2), .lock1_i(lk1_2), .clk_sel_o(sel2_o), .clk_en_o(en2_o),
    .busy_o(busy2_o), .ack_o(ack2_o), .err_o(err2_o)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // A select change is only legal while the gate is closed before and after it
  logic prev_sel = 1'b0, prev_en = 1'b1, prev_rst = 1'b0;
  logic prev_sel2 = 1'b0, prev_en2 = 1'b1;
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (sel_o !== prev_sel) chk("sel_change_gated", prev_en | en_o, 1'b0);
      if (sel2_o !== prev_sel2) chk("nt_sel_change_gated", prev_en2 | en2_o, 1'b0);
    end
    prev_sel  = sel_o;
    prev_en   = en_o;
    prev_sel2 = sel2_o;
    prev_en2  = en2_o;
    prev_rst  = rst_n;
  end

  // One handshake. r: first cycle the target lock is high (offset from request cycle 0).
  // dmode: 0 hold req until after ack, 1 drop after one cycle, 2 random drop.
  task automatic run_txn(input logic tgt, input int r, input int dmode, input bit mess);
    bit same, to;
    int l, s, gon, done, d, e;
    logic e_en, e_sel, e_busy, e_ack, e_err, tl;
    same = (tgt == cur_sel);
    l = (r < GW + 1) ? GW + 1 : r;
    to = !same && (l > GW + 1 + TO);
    if (same) begin
      done = 1; s = 0; gon = 0;
    end else if (to) begin
      gon = GW + 2 + TO; done = gon + GW; s = 1 << 30;
    end else begin
      s = l + 1; gon = s + MW; done = gon + GW;
    end
    case (dmode)
      0:       d = done + 2;
      1:       d = 1;
      default: d = $urandom_range(1, done + 3);
    endcase
    e = (d > done) ? d : done;
    for (int j = 0; j <= e + 1; j++) begin
      @(negedge clk);
      e_sel = (j > 0 && !same && !to && j >= s) ? tgt : cur_sel;
      if (j == 0 || j > e) begin
        e_en = 1'b1; e_busy = 1'b0; e_ack = 1'b0; e_err = 1'b0;
      end else begin
        e_en   = same ? 1'b1 : logic'(j >= gon);
        e_busy = 1'b1;
        e_ack  = logic'(j >= done);
        e_err  = to && (j >= done);
      end
      chk($sformatf("en c%0d", j),   en_o,   e_en);
      chk($sformatf("sel c%0d", j),  sel_o,  e_sel);
      chk($sformatf("busy c%0d", j), busy_o, e_busy);
      chk($sformatf("ack c%0d", j),  ack_o,  e_ack);
      chk($sformatf("err c%0d", j),  err_o,  e_err);
      req = logic'(j < d);
      sel = (mess && j > 0) ? 1'($urandom) : tgt;
      tl  = (j <= l) ? logic'(j >= r) : 1'($urandom);
      if (tgt) begin lk1 = tl; lk0 = 1'($urandom); end
      else     begin lk0 = tl; lk1 = 1'($urandom); end
    end
    if (!same && !to) cur_sel = tgt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_en", en_o, 1'b1);
    chk("rst_sel", sel_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_nt_en", en2_o, 1'b1);
    rst_n = 1'b1;

    run_txn(1'b1, 0, 0, 1'b0);    // nominal switch to source 1
    run_txn(1'b1, 0, 0, 1'b0);    // already selected: immediate ack
    run_txn(1'b0, 0, 0, 1'b0);
    run_txn(1'b1, 10, 0, 1'b0);   // late lock extends WAIT_LOCK
    run_txn(1'b0, 0, 0, 1'b0);
    run_txn(1'b1, 99, 0, 1'b0);   // lock never comes: timeout
    run_txn(1'b1, 21, 0, 1'b0);   // lock on the last allowed cycle
    run_txn(1'b1, 22, 0, 1'b0);   // lock one cycle too late
    run_txn(1'b1, 0, 1, 1'b1);    // early req drop, noisy sel_i
    run_txn(1'b0, 3, 1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) run_txn(1'($urandom), $urandom_range(22, 30), 2, 1'($urandom));
      else                           run_txn(1'($urandom), $urandom_range(0, 21), 2, 1'($urandom));
    end

    // Timeout disabled: wait indefinitely for lock
    @(negedge clk);
    chk("nt_idle_en", en2_o, 1'b1);
    req2 = 1'b1; sel2 = 1'b1; lk1_2 = 1'b0; lk0_2 = 1'b1;
    for (int j = 1; j <= 108; j++) begin
      @(negedge clk);
      chk($sformatf("nt_en c%0d", j),   en2_o,   logic'(j >= 103));
      chk($sformatf("nt_sel c%0d", j),  sel2_o,  logic'(j >= 101));
      chk($sformatf("nt_busy c%0d", j), busy2_o, logic'(j <= 107));
      chk($sformatf("nt_ack c%0d", j),  ack2_o,  logic'(j == 107));
      chk($sformatf("nt_err c%0d", j),  err2_o,  1'b0);
      req2  = logic'(j < 107);
      lk1_2 = logic'(j >= 100);
    end

    // Reset in the middle of a switch, after the select has flipped
    if (cur_sel) run_txn(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    req = 1'b1; sel = 1'b1; lk1 = 1'b1; lk0 = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk($sformatf("mid_en c%0d", j),  en_o,  1'b0);
      chk($sformatf("mid_sel c%0d", j), sel_o, logic'(j >= 6));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_en", en_o, 1'b1);
    chk("arst_sel", sel_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_ack", ack_o, 1'b0);
    chk("arst_err", err_o, 1'b0);
    req = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    cur_sel = 1'b0;
    run_txn(1'b1, 0, 0, 1'b0);    // recovers cleanly after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
